mem_responder: RTL and testbench

Multi-channel global-memory responder: the memory-side endpoint for the data/program cache controllers' per-channel read/write valid/ready handshake. It owns a 2^ADDR_BITS × DATA_BITS storage array, services each channel independently with a fixed programmable latency, and holds ready under a four-phase handshake. It is used as the simulation memory model and as an on-chip scratch memory behind the cache controllers.

---
 rtl/mem_responder_pkg.sv | 33 +++
 rtl/mem_responder_if.sv | 33 +++
 rtl/mem_responder_channel.sv | 116 +++++++++++
 rtl/mem_responder.sv | 82 ++++++++
 tb/tb_mem_responder.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the multi-channel memory responder: channel FSM
// state encoding, request op encoding, latency counter width and defaults.
package mem_responder_pkg;

  // Default geometry of the responder.
  localparam int DEF_ADDR_BITS    = 8;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_LATENCY      = 2;

  // Latency counter covers the full legal LATENCY range 1..15.
  localparam int CNT_W = $clog2(16);

  // Channel FSM state encoding (2 bits, kept as plain constants so older
  // blocks that compare against raw codes keep working).
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_BUSY      = 2'd1;
  localparam state_t ST_READ_ACK  = 2'd2;
  localparam state_t ST_WRITE_ACK = 2'd3;

  // Operation latched at request acceptance.
  typedef logic op_t;
  localparam op_t OP_READ  = 1'b0;
  localparam op_t OP_WRITE = 1'b1;

  // Counter preload for a given latency: the completion edge is the one on
  // which the counter is already zero.
  function automatic logic [CNT_W-1:0] cnt_preload(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Per-channel read/write valid/ready bus between the cache controllers
// (master) and the memory responder (slave). Channel i occupies slice i of
// every flattened vector.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
);

  logic [NUM_CHANNELS-1:0]           mem_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]           mem_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]           mem_write_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]           mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );

endinterface

// File: rtl/mem_responder_channel.sv
// One responder channel: accepts a read or write request, waits a fixed
// latency, then completes it and holds ready under a four-phase handshake.
// The storage array lives in the parent; this block exports commit/sample
// strobes and gets the array word at its latched address back.
module mem_responder_channel
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_read_valid,
  input  logic [ADDR_BITS-1:0] i_read_address,
  input  logic                 i_write_valid,
  input  logic [ADDR_BITS-1:0] i_write_address,
  input  logic [DATA_BITS-1:0] i_write_data,
  input  logic [DATA_BITS-1:0] i_array_rdata,
  output logic                 o_read_ready,
  output logic [DATA_BITS-1:0] o_read_data,
  output logic                 o_write_ready,
  output logic                 o_wr_commit,
  output logic [ADDR_BITS-1:0] o_wr_address,
  output logic [DATA_BITS-1:0] o_wr_data,
  output logic                 o_rd_sample,
  output logic [ADDR_BITS-1:0] o_rd_address
);

  state_t               r_state;
  op_t                  r_op;
  logic [CNT_W-1:0]     r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic                 r_read_ready;
  logic                 r_write_ready;
  logic [DATA_BITS-1:0] r_read_data;
  logic                 w_done;

  // The request completes on the BUSY edge where the counter has reached zero.
  assign w_done = (r_state == ST_BUSY) && (r_cnt == {CNT_W{1'b0}});

  // A commit coinciding with reset is dropped so in-flight writes never land.
  assign o_wr_commit  = w_done && (r_op == OP_WRITE) && !reset;
  assign o_wr_address = r_addr;
  assign o_wr_data    = r_wdata;
  assign o_rd_sample  = w_done && (r_op == OP_READ);
  assign o_rd_address = r_addr;

  assign o_read_ready  = r_read_ready;
  assign o_write_ready = r_write_ready;
  assign o_read_data   = r_read_data;

  // Channel FSM: accept (read has priority), count down, complete, handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_READ;
      r_cnt         <= {CNT_W{1'b0}};
      r_addr        <= {ADDR_BITS{1'b0}};
      r_wdata       <= {DATA_BITS{1'b0}};
      r_read_ready  <= 1'b0;
      r_write_ready <= 1'b0;
      r_read_data   <= {DATA_BITS{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_read_valid) begin
            r_addr  <= i_read_address;
            r_op    <= OP_READ;
            r_cnt   <= cnt_preload(LATENCY);
            r_state <= ST_BUSY;
          end else if (i_write_valid) begin
            r_addr  <= i_write_address;
            r_wdata <= i_write_data;
            r_op    <= OP_WRITE;
            r_cnt   <= cnt_preload(LATENCY);
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == {CNT_W{1'b0}}) begin
            if (r_op == OP_READ) begin
              r_read_data  <= i_array_rdata;
              r_read_ready <= 1'b1;
              r_state      <= ST_READ_ACK;
            end else begin
              r_write_ready <= 1'b1;
              r_state       <= ST_WRITE_ACK;
            end
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_READ_ACK: begin
          if (!i_read_valid) begin
            r_read_ready <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        ST_WRITE_ACK: begin
          if (!i_write_valid) begin
            r_write_ready <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_read_ready  <= 1'b0;
          r_write_ready <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-channel global-memory responder: owns the storage array and one
// independent request channel per cache-controller port.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int LATENCY      = DEF_LATENCY
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Storage is deliberately not reset; contents survive a reset.
  logic [DATA_BITS-1:0] r_mem [0:DEPTH-1];

  logic                 w_read_ready  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] w_read_data   [NUM_CHANNELS];
  logic                 w_write_ready [NUM_CHANNELS];
  logic                 w_wr_commit   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] w_wr_address  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] w_wr_data     [NUM_CHANNELS];
  logic                 w_rd_sample   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] w_rd_address  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] w_array_rdata [NUM_CHANNELS];

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    // Array word presented to the channel only on its sample edge; this is
    // the pre-commit value, so a same-edge write to the address is not seen.
    assign w_array_rdata[g] = w_rd_sample[g] ? r_mem[w_rd_address[g]]
                                             : {DATA_BITS{1'b0}};

    mem_responder_channel #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .LATENCY   (LATENCY)
    ) u_channel (
      .clk             (clk),
      .reset           (reset),
      .i_read_valid    (bus.mem_read_valid[g]),
      .i_read_address  (bus.mem_read_address[g*ADDR_BITS +: ADDR_BITS]),
      .i_write_valid   (bus.mem_write_valid[g]),
      .i_write_address (bus.mem_write_address[g*ADDR_BITS +: ADDR_BITS]),
      .i_write_data    (bus.mem_write_data[g*DATA_BITS +: DATA_BITS]),
      .i_array_rdata   (w_array_rdata[g]),
      .o_read_ready    (w_read_ready[g]),
      .o_read_data     (w_read_data[g]),
      .o_write_ready   (w_write_ready[g]),
      .o_wr_commit     (w_wr_commit[g]),
      .o_wr_address    (w_wr_address[g]),
      .o_wr_data       (w_wr_data[g]),
      .o_rd_sample     (w_rd_sample[g]),
      .o_rd_address    (w_rd_address[g])
    );
  end

  // Apply write commits in ascending channel order so the highest index wins.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (w_wr_commit[i]) begin
        r_mem[w_wr_address[i]] <= w_wr_data[i];
      end
    end
  end

  // Pack the per-channel registered outputs back onto the flattened bus.
  always_comb begin
    bus.mem_read_ready  = {NUM_CHANNELS{1'b0}};
    bus.mem_write_ready = {NUM_CHANNELS{1'b0}};
    bus.mem_read_data   = {(NUM_CHANNELS*DATA_BITS){1'b0}};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      bus.mem_read_ready[i]                        = w_read_ready[i];
      bus.mem_write_ready[i]                       = w_write_ready[i];
      bus.mem_read_data[i*DATA_BITS +: DATA_BITS]  = w_read_data[i];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic checked against a simple array model of the memory.
module tb_mem_responder;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) bus ();

  mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DB-1:0] mem_model [256];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.mem_read_valid    = '0;
    bus.mem_read_address  = '0;
    bus.mem_write_valid   = '0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
  endtask

  task automatic set_read(input int ch, input logic [AB-1:0] a);
    bus.mem_read_valid[ch]             = 1'b1;
    bus.mem_read_address[ch*AB +: AB]  = a;
  endtask

  task automatic set_write(input int ch, input logic [AB-1:0] a, input logic [DB-1:0] d);
    bus.mem_write_valid[ch]            = 1'b1;
    bus.mem_write_address[ch*AB +: AB] = a;
    bus.mem_write_data[ch*DB +: DB]    = d;
  endtask

  task automatic preload(input logic [AB-1:0] a, input logic [DB-1:0] d);
    dut.r_mem[a] = d;
    mem_model[a] = d;
  endtask

  function automatic logic [DB-1:0] rdat(input int ch);
    return bus.mem_read_data[ch*DB +: DB];
  endfunction

  // Count edges (after the acceptance edge) until read ready; bounded.
  task automatic wait_rd(input int ch, output int n);
    n = 0;
    while (bus.mem_read_ready[ch] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_wr(input int ch, output int n);
    n = 0;
    while (bus.mem_write_ready[ch] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    for (int a = 0; a < 256; a++) preload(a[AB-1:0], DB'($urandom));
    repeat (3) tick();
    n_tests++;
    if (bus.mem_read_ready !== 4'h0) begin
      n_fail++; $display("FAIL reset_rd_ready got=%h exp=0", bus.mem_read_ready);
    end
    n_tests++;
    if (bus.mem_write_ready !== 4'h0) begin
      n_fail++; $display("FAIL reset_wr_ready got=%h exp=0", bus.mem_write_ready);
    end
    n_tests++;
    if (bus.mem_read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd_data got=%h exp=0", bus.mem_read_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_latency();
    int n;
    preload(8'h10, 8'hA5);
    set_read(0, 8'h10);
    tick();
    wait_rd(0, n);
    n_tests++;
    if (n !== LAT) begin
      n_fail++; $display("FAIL read_latency got=%0d exp=%0d", n, LAT);
    end
    n_tests++;
    if (rdat(0) !== 8'hA5) begin
      n_fail++; $display("FAIL read_data got=%h exp=a5", rdat(0));
    end
    bus.mem_read_valid[0] = 1'b0;
    tick();
    n_tests++;
    if (bus.mem_read_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL read_ready_drop got=1 exp=0");
    end
    n_tests++;
    if (rdat(0) !== 8'hA5) begin
      n_fail++; $display("FAIL read_data_hold got=%h exp=a5", rdat(0));
    end
  endtask

  task automatic test_write_then_read();
    int n;
    set_write(1, 8'h20, 8'h3C);
    tick();
    wait_wr(1, n);
    mem_model[8'h20] = 8'h3C;
    n_tests++;
    if (n !== LAT) begin
      n_fail++; $display("FAIL write_latency got=%0d exp=%0d", n, LAT);
    end
    bus.mem_write_valid[1] = 1'b0;
    tick();
    n_tests++;
    if (bus.mem_write_ready[1] !== 1'b0) begin
      n_fail++; $display("FAIL write_ready_drop got=1 exp=0");
    end
    set_read(1, 8'h20);
    tick();
    wait_rd(1, n);
    n_tests++;
    if (n !== LAT || rdat(1) !== 8'h3C) begin
      n_fail++; $display("FAIL write_readback lat=%0d data=%h exp lat=%0d data=3c", n, rdat(1), LAT);
    end
    bus.mem_read_valid[1] = 1'b0;
    tick();
  endtask

  task automatic test_concurrent();
    int n;
    for (int i = 0; i < 4; i++) preload(i[AB-1:0], DB'(i + 1));
    for (int i = 0; i < 4; i++) set_read(i, i[AB-1:0]);
    tick();
    wait_rd(0, n);
    n_tests++;
    if (n !== LAT || bus.mem_read_ready !== 4'hF) begin
      n_fail++; $display("FAIL concurrent_ready lat=%0d ready=%h exp lat=%0d ready=f", n, bus.mem_read_ready, LAT);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rdat(i) !== DB'(i + 1)) begin
        n_fail++; $display("FAIL concurrent_data ch%0d got=%h exp=%h", i, rdat(i), DB'(i + 1));
      end
    end
    idle_inputs();
    tick();
    n_tests++;
    if (bus.mem_read_ready !== 4'h0) begin
      n_fail++; $display("FAIL concurrent_drop got=%h exp=0", bus.mem_read_ready);
    end
  endtask

  task automatic test_collision();
    int n;
    preload(8'h40, 8'h5A);
    set_write(0, 8'h40, 8'h11);
    set_write(3, 8'h40, 8'h22);
    set_read(2, 8'h40);
    tick();
    wait_rd(2, n);
    n_tests++;
    if (bus.mem_write_ready !== 4'h9) begin
      n_fail++; $display("FAIL collision_wr_ready got=%h exp=9", bus.mem_write_ready);
    end
    n_tests++;
    if (rdat(2) !== 8'h5A) begin
      n_fail++; $display("FAIL collision_old_value got=%h exp=5a", rdat(2));
    end
    mem_model[8'h40] = 8'h22;
    idle_inputs();
    tick();
    set_read(1, 8'h40);
    tick();
    wait_rd(1, n);
    n_tests++;
    if (rdat(1) !== 8'h22) begin
      n_fail++; $display("FAIL collision_winner got=%h exp=22", rdat(1));
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_held_and_early_drop();
    int n;
    int pulses;
    logic held_ok;
    logic [DB-1:0] d;
    set_read(3, 8'h10);
    tick();
    wait_rd(3, n);
    held_ok = 1'b1;
    repeat (5) begin
      tick();
      if (bus.mem_read_ready[3] !== 1'b1) held_ok = 1'b0;
    end
    n_tests++;
    if (held_ok !== 1'b1) begin
      n_fail++; $display("FAIL held_ready got=dropped exp=held");
    end
    bus.mem_read_valid[3] = 1'b0;
    tick();
    d = DB'($urandom);
    set_write(2, 8'h60, d);
    tick();
    bus.mem_write_valid[2] = 1'b0;
    pulses = 0;
    repeat (8) begin
      tick();
      if (bus.mem_write_ready[2] === 1'b1) pulses++;
    end
    mem_model[8'h60] = d;
    n_tests++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL early_drop_pulse got=%0d cycles exp=1", pulses);
    end
    set_read(2, 8'h60);
    tick();
    wait_rd(2, n);
    n_tests++;
    if (rdat(2) !== d) begin
      n_fail++; $display("FAIL early_drop_commit got=%h exp=%h", rdat(2), d);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_read_priority();
    int n;
    preload(8'h70, 8'h12);
    set_read(2, 8'h70);
    set_write(2, 8'h70, 8'h34);
    tick();
    wait_rd(2, n);
    n_tests++;
    if (n !== LAT || rdat(2) !== 8'h12 || bus.mem_write_ready[2] !== 1'b0) begin
      n_fail++; $display("FAIL read_priority lat=%0d data=%h wr_ready=%b exp lat=%0d data=12 wr_ready=0",
                         n, rdat(2), bus.mem_write_ready[2], LAT);
    end
    bus.mem_read_valid[2] = 1'b0;
    tick();
    tick();
    wait_wr(2, n);
    mem_model[8'h70] = 8'h34;
    n_tests++;
    if (n !== LAT) begin
      n_fail++; $display("FAIL pending_write lat=%0d exp=%0d", n, LAT);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_write();
    int n;
    preload(8'h50, 8'h99);
    set_write(0, 8'h50, 8'h77);
    tick();
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    n_tests++;
    if (bus.mem_write_ready !== 4'h0 || bus.mem_read_ready !== 4'h0) begin
      n_fail++; $display("FAIL reset_mid_ready wr=%h rd=%h exp 0/0", bus.mem_write_ready, bus.mem_read_ready);
    end
    n_tests++;
    if (bus.mem_read_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_rd_data got=%h exp=0", bus.mem_read_data);
    end
    set_read(0, 8'h50);
    tick();
    wait_rd(0, n);
    n_tests++;
    if (rdat(0) !== 8'h99) begin
      n_fail++; $display("FAIL reset_mid_retained got=%h exp=99", rdat(0));
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random_serial();
    int n;
    int ch;
    int hold;
    logic held_ok;
    logic is_wr;
    logic [AB-1:0] a;
    logic [DB-1:0] d;
    for (int it = 0; it < 40; it++) begin
      ch    = $urandom_range(0, NC - 1);
      is_wr = 1'($urandom_range(0, 1));
      a     = AB'($urandom_range(0, 255));
      d     = DB'($urandom);
      hold  = $urandom_range(0, 3);
      if (is_wr) set_write(ch, a, d);
      else       set_read(ch, a);
      tick();
      if (is_wr) wait_wr(ch, n);
      else       wait_rd(ch, n);
      n_tests++;
      if (n !== LAT) begin
        n_fail++; $display("FAIL rand_latency it=%0d ch=%0d got=%0d exp=%0d", it, ch, n, LAT);
      end
      if (is_wr) begin
        mem_model[a] = d;
      end else begin
        n_tests++;
        if (rdat(ch) !== mem_model[a]) begin
          n_fail++; $display("FAIL rand_read it=%0d ch=%0d addr=%h got=%h exp=%h", it, ch, a, rdat(ch), mem_model[a]);
        end
      end
      held_ok = 1'b1;
      repeat (hold) begin
        tick();
        if ((is_wr ? bus.mem_write_ready[ch] : bus.mem_read_ready[ch]) !== 1'b1) held_ok = 1'b0;
      end
      idle_inputs();
      tick();
      n_tests++;
      if (held_ok !== 1'b1 || bus.mem_read_ready !== 4'h0 || bus.mem_write_ready !== 4'h0) begin
        n_fail++; $display("FAIL rand_handshake it=%0d held=%b rd=%h wr=%h", it, held_ok, bus.mem_read_ready, bus.mem_write_ready);
      end
    end
  endtask

  task automatic test_random_parallel();
    logic [NC-1:0] rd_mask;
    logic [NC-1:0] wr_mask;
    logic [DB-1:0] exp_rd [NC];
    logic [AB-1:0] a [NC];
    logic [DB-1:0] d [NC];
    for (int it = 0; it < 15; it++) begin
      rd_mask = '0;
      wr_mask = '0;
      for (int i = 0; i < NC; i++) begin
        a[i] = AB'(8'hC0 + $urandom_range(0, 3));
        d[i] = DB'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          wr_mask[i] = 1'b1;
          set_write(i, a[i], d[i]);
        end else begin
          rd_mask[i] = 1'b1;
          set_read(i, a[i]);
        end
      end
      // reads see the array as it was before this round's commits
      for (int i = 0; i < NC; i++) exp_rd[i] = mem_model[a[i]];
      for (int i = 0; i < NC; i++) if (wr_mask[i]) mem_model[a[i]] = d[i];
      tick();
      repeat (LAT) tick();
      n_tests++;
      if (bus.mem_read_ready !== rd_mask || bus.mem_write_ready !== wr_mask) begin
        n_fail++; $display("FAIL par_ready it=%0d rd=%h/%h wr=%h/%h", it, bus.mem_read_ready, rd_mask, bus.mem_write_ready, wr_mask);
      end
      for (int i = 0; i < NC; i++) begin
        if (rd_mask[i]) begin
          n_tests++;
          if (rdat(i) !== exp_rd[i]) begin
            n_fail++; $display("FAIL par_read it=%0d ch=%0d got=%h exp=%h", it, i, rdat(i), exp_rd[i]);
          end
        end
      end
      idle_inputs();
      tick();
    end
    // final sweep reads back the contended addresses
    for (int i = 0; i < NC; i++) set_read(i, AB'(8'hC0 + i));
    tick();
    repeat (LAT) tick();
    for (int i = 0; i < NC; i++) begin
      n_tests++;
      if (rdat(i) !== mem_model[8'hC0 + i]) begin
        n_fail++; $display("FAIL par_final ch=%0d got=%h exp=%h", i, rdat(i), mem_model[8'hC0 + i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_concurrent();
    test_collision();
    test_held_and_early_drop();
    test_read_priority();
    test_reset_mid_write();
    test_random_serial();
    test_random_parallel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
